gemm_result_writeback: RTL and testbench

GEMM_RESULT_WRITEBACK -- requirements
Module: gemm_result_writeback

---
 rtl/gemm_result_writeback.sv | 188 ++++++++++++++++++
 tb/tb_gemm_result_writeback.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gemm_result_writeback.sv
// ============================================================================
// Module      : gemm_result_writeback
// Description : Buffers GeMM result elements in a small first-word-fall-through
//               FIFO and writes them row-major to memory at
//               base + row*stride + col.
//               Optional macro: GEMM_WB_OVERFLOW_DETECT_EN (sticky overflow flag).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gemm_result_writeback #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 16,
    parameter int FifoDepth = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [AddrWidth-1:0] M_size_i,
    input  logic [AddrWidth-1:0] N_size_i,
    input  logic [AddrWidth-1:0] base_addr_i,
    input  logic [AddrWidth-1:0] row_stride_i,
    input  logic                 result_valid_i,
    input  logic [DataWidth-1:0] result_data_i,
    output logic                 mem_valid_o,
    input  logic                 mem_ready_i,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic [DataWidth-1:0] mem_wdata_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 overflow_o
);

    localparam int PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int CntW = PtrW + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t               state;
    logic [AddrWidth-1:0] m_size;
    logic [AddrWidth-1:0] n_size;
    logic [AddrWidth-1:0] row_stride;
    logic [AddrWidth-1:0] row_ptr;
    logic [AddrWidth-1:0] col_cnt;
    logic [AddrWidth-1:0] row_cnt;
    logic                 busy_r;
    logic                 done_r;

    logic [DataWidth-1:0] fifo_mem [FifoDepth];
    logic [PtrW-1:0]      wr_ptr;
    logic [PtrW-1:0]      rd_ptr;
    logic [CntW-1:0]      count;

    logic job_empty;
    logic fifo_full;
    logic push_req;
    logic push_ok;
    logic pop;
    logic last_col;
    logic last_row;

    assign job_empty   = (m_size == '0) || (n_size == '0);
    assign fifo_full   = (count == CntW'(FifoDepth));
    assign mem_valid_o = (count != '0);
    assign mem_wdata_o = fifo_mem[rd_ptr];
    assign mem_addr_o  = row_ptr + col_cnt;
    assign busy_o      = busy_r;
    assign done_o      = done_r;

    assign pop      = (state == ACTIVE) && mem_valid_o && mem_ready_i;
    // A zero-sized job never buffers anything, so no request can ever appear.
    assign push_req = (state == ACTIVE) && !job_empty && result_valid_i;
    assign push_ok  = push_req && (!fifo_full || pop);
    assign last_col = (col_cnt == n_size - AddrWidth'(1));
    assign last_row = (row_cnt == m_size - AddrWidth'(1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FifoDepth; i++) begin
                fifo_mem[i] <= '0;
            end
        end else if (state == FINISH) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                fifo_mem[wr_ptr] <= result_data_i;
                wr_ptr           <= wr_ptr + PtrW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PtrW'(1);
            end
            if (push_ok && !pop) begin
                count <= count + CntW'(1);
            end else if (!push_ok && pop) begin
                count <= count - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            m_size     <= '0;
            n_size     <= '0;
            row_stride <= '0;
            row_ptr    <= '0;
            col_cnt    <= '0;
            row_cnt    <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start_i) begin
                        m_size     <= M_size_i;
                        n_size     <= N_size_i;
                        row_stride <= row_stride_i;
                        row_ptr    <= base_addr_i;
                        col_cnt    <= '0;
                        row_cnt    <= '0;
                        busy_r     <= 1'b1;
                        state      <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (job_empty) begin
                        done_r <= 1'b1;
                        state  <= FINISH;
                    end else if (pop) begin
                        if (last_col) begin
                            col_cnt <= '0;
                            row_cnt <= row_cnt + AddrWidth'(1);
                            row_ptr <= row_ptr + row_stride;
                            if (last_row) begin
                                done_r <= 1'b1;
                                state  <= FINISH;
                            end
                        end else begin
                            col_cnt <= col_cnt + AddrWidth'(1);
                        end
                    end
                end
                FINISH: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    col_cnt <= '0;
                    row_cnt <= '0;
                    row_ptr <= '0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef GEMM_WB_OVERFLOW_DETECT_EN
    logic overflow_r;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_r <= 1'b0;
        end else if ((state == IDLE) && start_i) begin
            overflow_r <= 1'b0;
        end else if (push_req && fifo_full && !pop) begin
            overflow_r <= 1'b1;
        end
    end

    assign overflow_o = overflow_r;
`else
    assign overflow_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gemm_result_writeback.sv
// ============================================================================
// Module      : tb_gemm_result_writeback
// Description : Directed, table-driven bench for gemm_result_writeback.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gemm_result_writeback;

`ifdef GEMM_WB_OVERFLOW_DETECT_EN
    localparam logic OVF = 1'b1;
`else
    localparam logic OVF = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] m_size;
    logic [15:0] n_size;
    logic [15:0] base_addr;
    logic [15:0] row_stride;
    logic        result_valid;
    logic [31:0] result_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        overflow;

    gemm_result_writeback #(
        .DataWidth(32),
        .AddrWidth(16),
        .FifoDepth(4)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .start_i       (start),
        .M_size_i      (m_size),
        .N_size_i      (n_size),
        .base_addr_i   (base_addr),
        .row_stride_i  (row_stride),
        .result_valid_i(result_valid),
        .result_data_i (result_data),
        .mem_valid_o   (mem_valid),
        .mem_ready_i   (mem_ready),
        .mem_addr_o    (mem_addr),
        .mem_wdata_o   (mem_wdata),
        .busy_o        (busy),
        .done_o        (done),
        .overflow_o    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [15:0] cap_addr[$];
    logic [31:0] cap_data[$];
    int done_cnt, busy_cnt, valid_cnt, done_cyc, last_hs_cyc;

    always @(posedge clk) cyc++;

    // Inputs change #1 after posedge, so negedge sees exactly what the next edge will.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_valid && mem_ready) begin
                cap_addr.push_back(mem_addr);
                cap_data.push_back(mem_wdata);
                last_hs_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (busy)      busy_cnt++;
            if (mem_valid) valid_cnt++;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        cap_addr.delete();
        cap_data.delete();
        done_cnt  = 0;
        busy_cnt  = 0;
        valid_cnt = 0;
    endtask

    task automatic run_job(input logic [15:0] m, input logic [15:0] n, input logic [15:0] b,
                           input logic [15:0] s, input int nres, input logic [31:0] dbase);
        @(posedge clk); #1;
        start = 1'b1; m_size = m; n_size = n; base_addr = b; row_stride = s;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < nres; k++) begin
            result_valid = 1'b1;
            result_data  = dbase + 32'(k);
            @(posedge clk); #1;
        end
        result_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_timeout", 64'(n >= budget), 64'(0));
        @(posedge clk); #1;
    endtask

    function automatic logic [15:0] cap_a(input int k);
        return (k < cap_addr.size()) ? cap_addr[k] : 16'hDEAD;
    endfunction

    function automatic logic [31:0] cap_d(input int k);
        return (k < cap_data.size()) ? cap_data[k] : 32'hDEADDEAD;
    endfunction

    typedef struct packed {
        logic [15:0] m;
        logic [15:0] n;
        logic [15:0] base;
        logic [15:0] stride;
        logic [7:0]  nw;
    } job_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;

    job_t jobs[3];
    wr_t  exp_wr[13];

    initial begin
        int wi;

        jobs[0] = '{16'd2, 16'd3, 16'h0100, 16'h0010, 8'd6};
        jobs[1] = '{16'd2, 16'd2, 16'hFFFE, 16'h0003, 8'd4};
        jobs[2] = '{16'd3, 16'd1, 16'h0020, 16'h0100, 8'd3};
        exp_wr[0]  = '{16'h0100, 32'hA000_0000};
        exp_wr[1]  = '{16'h0101, 32'hA000_0001};
        exp_wr[2]  = '{16'h0102, 32'hA000_0002};
        exp_wr[3]  = '{16'h0110, 32'hA000_0003};
        exp_wr[4]  = '{16'h0111, 32'hA000_0004};
        exp_wr[5]  = '{16'h0112, 32'hA000_0005};
        exp_wr[6]  = '{16'hFFFE, 32'hA000_0100};
        exp_wr[7]  = '{16'hFFFF, 32'hA000_0101};
        exp_wr[8]  = '{16'h0001, 32'hA000_0102};
        exp_wr[9]  = '{16'h0002, 32'hA000_0103};
        exp_wr[10] = '{16'h0020, 32'hA000_0200};
        exp_wr[11] = '{16'h0120, 32'hA000_0201};
        exp_wr[12] = '{16'h0220, 32'hA000_0202};

        rst_n = 1'b0; start = 1'b0; m_size = '0; n_size = '0; base_addr = '0;
        row_stride = '0; result_valid = 1'b0; result_data = '0; mem_ready = 1'b1;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {mem_valid, done, busy, overflow, mem_addr, mem_wdata}, 64'(0));
        rst_n = 1'b1;

        // Results offered in Idle must be dropped.
        result_valid = 1'b1; result_data = 32'h5555_5555;
        repeat (3) @(posedge clk);
        #1;
        result_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("idle_drop_valid", 64'(valid_cnt), 64'(0));

        wi = 0;
        for (int j = 0; j < 3; j++) begin
            clear_mon();
            run_job(jobs[j].m, jobs[j].n, jobs[j].base, jobs[j].stride, int'(jobs[j].nw),
                    32'hA000_0000 + 32'(j * 256));
            wait_idle(50);
            check("job_writes", 64'(cap_addr.size()), 64'(jobs[j].nw));
            for (int k = 0; k < int'(jobs[j].nw); k++) begin
                check("wr_addr", 64'(cap_a(k)), 64'(exp_wr[wi].addr));
                check("wr_data", 64'(cap_d(k)), 64'(exp_wr[wi].data));
                wi++;
            end
            check("job_done", 64'(done_cnt), 64'(1));
            if (j == 0) check("done_latency", 64'(done_cyc), 64'(last_hs_cyc + 1));
        end

        // Four results buffered while memory stalls.
        clear_mon();
        mem_ready = 1'b0;
        run_job(16'd1, 16'd4, 16'h0040, 16'h0000, 4, 32'hB000_0000);
        check("stall_head", {mem_valid, 15'd0, mem_addr, mem_wdata}, {1'b1, 15'd0, 16'h0040, 32'hB000_0000});
        repeat (6) @(posedge clk);
        #1;
        check("stall_hold", {mem_valid, 15'd0, mem_addr, mem_wdata}, {1'b1, 15'd0, 16'h0040, 32'hB000_0000});
        mem_ready = 1'b1;
        wait_idle(50);
        check("nodrop_writes", 64'(cap_addr.size()), 64'(4));
        for (int k = 0; k < 4; k++) begin
            check("nodrop_wr", {cap_a(k), cap_d(k)}, {16'h0040 + 16'(k), 32'hB000_0000 + 32'(k)});
        end
        check("nodrop_ovf", 64'(overflow), 64'(0));
        check("nodrop_done", 64'(done_cnt), 64'(1));

        // Six results into a 4-deep buffer: last two dropped.
        clear_mon();
        mem_ready = 1'b0;
        run_job(16'd1, 16'd4, 16'h0040, 16'h0000, 6, 32'hC000_0000);
        check("drop_ovf_set", 64'(overflow), 64'(OVF));
        repeat (6) @(posedge clk);
        #1;
        mem_ready = 1'b1;
        wait_idle(50);
        check("drop_writes", 64'(cap_addr.size()), 64'(4));
        for (int k = 0; k < 4; k++) begin
            check("drop_wr_data", 64'(cap_d(k)), 64'(32'hC000_0000 + 32'(k)));
        end
        check("drop_done", 64'(done_cnt), 64'(1));
        check("drop_ovf_sticky", 64'(overflow), 64'(OVF));

        // Zero-row job; its start also clears the overflow flag.
        clear_mon();
        run_job(16'd0, 16'd5, 16'h0000, 16'h0000, 2, 32'hD000_0000);
        check("zero_ovf_clear", 64'(overflow), 64'(0));
        wait_idle(50);
        check("zero_busy_cycles", 64'(busy_cnt), 64'(2));
        check("zero_done", 64'(done_cnt), 64'(1));
        check("zero_no_valid", 64'(valid_cnt), 64'(0));

        // Full buffer with a simultaneous pop and push.
        clear_mon();
        mem_ready = 1'b0;
        run_job(16'd1, 16'd5, 16'h0080, 16'h0000, 4, 32'hE000_0000);
        mem_ready = 1'b1; result_valid = 1'b1; result_data = 32'hE000_0004;
        @(posedge clk); #1;
        result_valid = 1'b0;
        wait_idle(50);
        check("fullpop_writes", 64'(cap_addr.size()), 64'(5));
        check("fullpop_last", {cap_a(4), cap_d(4)}, {16'h0084, 32'hE000_0004});
        check("fullpop_ovf", 64'(overflow), 64'(0));
        check("fullpop_done", 64'(done_cnt), 64'(1));

        // Reset in the middle of a job.
        clear_mon();
        mem_ready = 1'b0;
        run_job(16'd2, 16'd2, 16'h0200, 16'h0010, 4, 32'hF000_0000);
        mem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midreset_outputs", {mem_valid, done, busy, overflow, mem_addr, mem_wdata}, 64'(0));
        check("midreset_hs", {16'(cap_addr.size()), cap_a(0), cap_a(1)}, {16'd2, 16'h0200, 16'h0201});
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        check("postreset_quiet", {32'(valid_cnt), 32'(busy_cnt)}, 64'(0));
        run_job(16'd1, 16'd1, 16'h0000, 16'h0000, 1, 32'h1234_5678);
        wait_idle(50);
        check("newjob_wr", {16'(cap_addr.size()), cap_a(0), cap_d(0)}, {16'd1, 16'h0000, 32'h1234_5678});
        check("newjob_done", 64'(done_cnt), 64'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
